// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a latency-matched sync/blanking delay line.
// Optional macro VGA_TEST_PATTERN_EN swaps the colour inputs for an internal counter pattern.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CNT_W     = 11,
   parameter int COLOR_W   = 4,
   parameter int PIPE      = 2
) (
   input  logic               vgaclk,
   input  logic               sys_rst,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               de_req,
   output logic               frame_start,
   output logic               line_start,
   input  logic [COLOR_W-1:0] red_in,
   input  logic [COLOR_W-1:0] green_in,
   input  logic [COLOR_W-1:0] blue_in,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] red_out,
   output logic [COLOR_W-1:0] green_out,
   output logic [COLOR_W-1:0] blue_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // run holds the counters at 0/0 for the first edge after reset so that
   // position 0/0 is presented with de_req and frame_start already decoded.
   logic             run;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;

   always_comb begin
      h_nxt = hcount;
      v_nxt = vcount;
      if (run) begin
         if (hcount == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
         end else begin
            h_nxt = hcount + 1'b1;
         end
      end
   end

   always_ff @(posedge vgaclk or posedge sys_rst) begin
      if (sys_rst) begin
         run         <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         de_req      <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         run         <= 1'b1;
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         de_req      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         line_start  <= (h_nxt == '0);
         frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end
   end

   // Sync flags are carried as "asserted" bits; polarity is applied at the pins.
   logic       hs_raw;
   logic       vs_raw;
   logic [2:0] ctl_raw;
   logic [2:0] ctl_p;

   assign hs_raw  = run && (hcount >= HS_BEG) && (hcount < HS_END);
   assign vs_raw  = run && (vcount >= VS_BEG) && (vcount < VS_END);
   assign ctl_raw = {de_req, hs_raw, vs_raw};

`ifdef VGA_TEST_PATTERN_EN
   logic [CNT_W-1:0] hc_p;
   logic [CNT_W-1:0] vc_p;
`endif

   generate
      if (PIPE == 0) begin : g_direct
         assign ctl_p = ctl_raw;
`ifdef VGA_TEST_PATTERN_EN
         assign hc_p = hcount;
         assign vc_p = vcount;
`endif
      end else begin : g_delay
         logic [2:0] ctl_sr [PIPE];

         always_ff @(posedge vgaclk or posedge sys_rst) begin
            if (sys_rst) begin
               for (int i = 0; i < PIPE; i++) ctl_sr[i] <= '0;
            end else begin
               ctl_sr[0] <= ctl_raw;
               for (int i = 1; i < PIPE; i++) ctl_sr[i] <= ctl_sr[i-1];
            end
         end

         assign ctl_p = ctl_sr[PIPE-1];

`ifdef VGA_TEST_PATTERN_EN
         logic [2*CNT_W-1:0] cnt_sr [PIPE];

         always_ff @(posedge vgaclk or posedge sys_rst) begin
            if (sys_rst) begin
               for (int i = 0; i < PIPE; i++) cnt_sr[i] <= '0;
            end else begin
               cnt_sr[0] <= {vcount, hcount};
               for (int i = 1; i < PIPE; i++) cnt_sr[i] <= cnt_sr[i-1];
            end
         end

         assign {vc_p, hc_p} = cnt_sr[PIPE-1];
`endif
      end
   endgenerate

   logic [COLOR_W-1:0] red_src;
   logic [COLOR_W-1:0] green_src;
   logic [COLOR_W-1:0] blue_src;

`ifdef VGA_TEST_PATTERN_EN
   // Counters are widened first so narrow CNT_W still yields a defined pattern.
   logic [CNT_W+7:0] hx;
   logic [CNT_W+7:0] vx;
   assign hx        = {8'd0, hc_p};
   assign vx        = {8'd0, vc_p};
   assign red_src   = COLOR_W'(vx[5:2]);
   assign green_src = COLOR_W'(hx[5:2]);
   assign blue_src  = COLOR_W'(hx[7:4]);
`else
   assign red_src   = red_in;
   assign green_src = green_in;
   assign blue_src  = blue_in;
`endif

   always_ff @(posedge vgaclk or posedge sys_rst) begin
      if (sys_rst) begin
         hsync     <= ~HSYNC_POL;
         vsync     <= ~VSYNC_POL;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
      end else begin
         hsync     <= ctl_p[1] ? HSYNC_POL : ~HSYNC_POL;
         vsync     <= ctl_p[0] ? VSYNC_POL : ~VSYNC_POL;
         red_out   <= ctl_p[2] ? red_src   : '0;
         green_out <= ctl_p[2] ? green_src : '0;
         blue_out  <= ctl_p[2] ? blue_src  : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance and a tiny active-high-sync instance,
// both checked every cycle against an arithmetic raster model driven by random colour input.
module tb_vga_timing_gen;

   localparam int B_PIPE = 2;
   localparam int S_PIPE = 3;
   localparam int B_HT   = 1056;
   localparam int B_VT   = 628;
   localparam int S_HT   = 14;
   localparam int S_VT   = 7;

   logic vgaclk    = 1'b0;
   logic rst_big   = 1'b1;
   logic rst_small = 1'b1;
   logic [3:0] red_in   = '0;
   logic [3:0] green_in = '0;
   logic [3:0] blue_in  = '0;
   logic [11:0] prev_rgb = '0;

   always #5 vgaclk = ~vgaclk;

   logic [10:0] b_hcount, b_vcount, s_hcount, s_vcount;
   logic        b_de_req, b_frame_start, b_line_start, b_hsync, b_vsync;
   logic        s_de_req, s_frame_start, s_line_start, s_hsync, s_vsync;
   logic [3:0]  b_red_out, b_green_out, b_blue_out;
   logic [3:0]  s_red_out, s_green_out, s_blue_out;

   vga_timing_gen #(.PIPE(B_PIPE)) u_big (
      .vgaclk(vgaclk), .sys_rst(rst_big),
      .hcount(b_hcount), .vcount(b_vcount), .de_req(b_de_req),
      .frame_start(b_frame_start), .line_start(b_line_start),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .hsync(b_hsync), .vsync(b_vsync),
      .red_out(b_red_out), .green_out(b_green_out), .blue_out(b_blue_out));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(S_PIPE)
   ) u_small (
      .vgaclk(vgaclk), .sys_rst(rst_small),
      .hcount(s_hcount), .vcount(s_vcount), .de_req(s_de_req),
      .frame_start(s_frame_start), .line_start(s_line_start),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .hsync(s_hsync), .vsync(s_vsync),
      .red_out(s_red_out), .green_out(s_green_out), .blue_out(s_blue_out));

   logic [24:0] b_ctrl, s_ctrl;
   logic [13:0] b_pins, s_pins;
   assign b_ctrl = {b_hcount, b_vcount, b_de_req, b_frame_start, b_line_start};
   assign s_ctrl = {s_hcount, s_vcount, s_de_req, s_frame_start, s_line_start};
   assign b_pins = {b_hsync, b_vsync, b_red_out, b_green_out, b_blue_out};
   assign s_pins = {s_hsync, s_vsync, s_red_out, s_green_out, s_blue_out};

   int checks = 0;
   int errors = 0;

   // Cycle index since reset release: 0 is the first cycle after the first edge.
   int k_big   = -1;
   int k_small = -1;
   always @(posedge vgaclk or posedge rst_big)
      if (rst_big) k_big = -1; else k_big = k_big + 1;
   always @(posedge vgaclk or posedge rst_small)
      if (rst_small) k_small = -1; else k_small = k_small + 1;

   // Random colour changes shortly after each edge; prev_rgb is what the last edge sampled.
   initial forever begin
      @(posedge vgaclk);
      #1;
      prev_rgb = {red_in, green_in, blue_in};
      {red_in, green_in, blue_in} = 12'($urandom);
   end

   function automatic logic [24:0] exp_ctrl(int k, int ha, int ht, int va, int vt);
      int x, y;
      if (k < 0) return '0;
      x = k % ht;
      y = (k / ht) % vt;
      return {11'(x), 11'(y), (x < ha) && (y < va), (x == 0) && (y == 0), x == 0};
   endfunction

   // Pins at cycle k show the request made at k-1-pipe, coloured by the last sampled input.
   function automatic logic [13:0] exp_pins(int k, int pipe, int ha, int hf, int hsw, int ht,
                                            int va, int vf, int vsw, int vt,
                                            bit hpol, bit vpol, logic [11:0] in_rgb);
      int r, x, y;
      logic hs, vs, de;
      logic [11:0] rgb;
      r = k - 1 - pipe;
      hs = 1'b0; vs = 1'b0; de = 1'b0; rgb = '0;
      if (r >= 0) begin
         x  = r % ht;
         y  = (r / ht) % vt;
         hs = (x >= ha + hf) && (x < ha + hf + hsw);
         vs = (y >= va + vf) && (y < va + vf + vsw);
         de = (x < ha) && (y < va);
`ifdef VGA_TEST_PATTERN_EN
         rgb = {4'(y >> 2), 4'(x >> 2), 4'(x >> 4)};
`else
         rgb = in_rgb;
`endif
      end
      return {hs ? hpol : ~hpol, vs ? vpol : ~vpol, de ? rgb : 12'h000};
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge vgaclk);
      checks++;
      if ({b_ctrl, b_pins} !== {25'd0, 2'b11, 12'h000}) begin
         errors++;
         $display("FAIL reset_big got %h %h want %h %h", b_ctrl, b_pins, 25'd0, 14'h3000);
      end
      checks++;
      if ({s_ctrl, s_pins} !== {25'd0, 2'b00, 12'h000}) begin
         errors++;
         $display("FAIL reset_small got %h %h want %h %h", s_ctrl, s_pins, 25'd0, 14'h0000);
      end
      rst_big = 1'b0;
      rst_small = 1'b0;
      @(negedge vgaclk);
      checks++;
      if (b_ctrl !== {11'd0, 11'd0, 3'b111}) begin
         errors++;
         $display("FAIL first_cycle_big got %h want %h", b_ctrl, {11'd0, 11'd0, 3'b111});
      end
      checks++;
      if (s_ctrl !== {11'd0, 11'd0, 3'b111}) begin
         errors++;
         $display("FAIL first_cycle_small got %h want %h", s_ctrl, {11'd0, 11'd0, 3'b111});
      end
   endtask

   task automatic test_default_lines();
      logic [24:0] ec;
      logic [13:0] ep;
      repeat (3 * B_HT + 20) begin
         @(negedge vgaclk);
         ec = exp_ctrl(k_big, 800, B_HT, 600, B_VT);
         ep = exp_pins(k_big, B_PIPE, 800, 40, 128, B_HT, 600, 1, 4, B_VT, 1'b0, 1'b0, prev_rgb);
         checks++;
         if (b_ctrl !== ec) begin
            errors++;
            $display("FAIL big_ctrl k=%0d got %h want %h", k_big, b_ctrl, ec);
         end
         checks++;
         if (b_pins !== ep) begin
            errors++;
            $display("FAIL big_pins k=%0d got %h want %h", k_big, b_pins, ep);
         end
      end
   endtask

   task automatic test_default_hsync();
      int lows, first, budget;
      budget = 0;
      do begin
         @(negedge vgaclk);
         budget++;
      end while ((k_big % B_HT) != 0 && budget < 2 * B_HT);
      checks++;
      if ((k_big % B_HT) != 0) begin
         errors++;
         $display("FAIL hsync_align timeout k=%0d want line boundary", k_big);
      end
      lows = 0;
      first = -1;
      for (int i = 0; i < B_HT; i++) begin
         if (b_hsync === 1'b0) begin
            lows++;
            if (first < 0) first = i;
         end
         @(negedge vgaclk);
      end
      checks++;
      if (lows != 128) begin
         errors++;
         $display("FAIL hsync_width got %0d want 128", lows);
      end
      checks++;
      if (first != 840 + B_PIPE + 1) begin
         errors++;
         $display("FAIL hsync_start got %0d want %0d", first, 840 + B_PIPE + 1);
      end
   endtask

   task automatic test_small_geometry();
      logic [24:0] ec;
      logic [13:0] ep;
      int hs_hi, vs_hi, hmax, vmax;
      hs_hi = 0; vs_hi = 0; hmax = 0; vmax = 0;
      for (int i = 0; i < 3 * S_HT * S_VT; i++) begin
         @(negedge vgaclk);
         ec = exp_ctrl(k_small, 8, S_HT, 4, S_VT);
         ep = exp_pins(k_small, S_PIPE, 8, 2, 2, S_HT, 4, 1, 1, S_VT, 1'b1, 1'b1, prev_rgb);
         checks++;
         if (s_ctrl !== ec) begin
            errors++;
            $display("FAIL small_ctrl k=%0d got %h want %h", k_small, s_ctrl, ec);
         end
         checks++;
         if (s_pins !== ep) begin
            errors++;
            $display("FAIL small_pins k=%0d got %h want %h", k_small, s_pins, ep);
         end
         if (i < S_HT * S_VT) begin
            if (s_hsync === 1'b1) hs_hi++;
            if (s_vsync === 1'b1) vs_hi++;
         end
         if (int'(s_hcount) > hmax) hmax = int'(s_hcount);
         if (int'(s_vcount) > vmax) vmax = int'(s_vcount);
      end
      checks++;
      if (hs_hi != 2 * S_VT) begin
         errors++;
         $display("FAIL small_hsync_high got %0d want %0d", hs_hi, 2 * S_VT);
      end
      checks++;
      if (vs_hi != S_HT) begin
         errors++;
         $display("FAIL small_vsync_high got %0d want %0d", vs_hi, S_HT);
      end
      checks++;
      if (hmax != 13 || vmax != 6) begin
         errors++;
         $display("FAIL small_wrap got %0d/%0d want 13/6", hmax, vmax);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [24:0] ec;
      logic [13:0] ep;
      repeat ($urandom_range(200, 900)) @(negedge vgaclk);
      rst_big = 1'b1;
      rst_small = 1'b1;
      #1;
      checks++;
      if ({b_ctrl, b_pins} !== {25'd0, 2'b11, 12'h000}) begin
         errors++;
         $display("FAIL midreset_big got %h %h want %h %h", b_ctrl, b_pins, 25'd0, 14'h3000);
      end
      checks++;
      if ({s_ctrl, s_pins} !== {25'd0, 2'b00, 12'h000}) begin
         errors++;
         $display("FAIL midreset_small got %h %h want %h %h", s_ctrl, s_pins, 25'd0, 14'h0000);
      end
      repeat (3) @(negedge vgaclk);
      rst_big = 1'b0;
      rst_small = 1'b0;
      repeat (B_HT + 40) begin
         @(negedge vgaclk);
         ec = exp_ctrl(k_big, 800, B_HT, 600, B_VT);
         ep = exp_pins(k_big, B_PIPE, 800, 40, 128, B_HT, 600, 1, 4, B_VT, 1'b0, 1'b0, prev_rgb);
         checks++;
         if ({b_ctrl, b_pins} !== {ec, ep}) begin
            errors++;
            $display("FAIL after_reset_big k=%0d got %h %h want %h %h", k_big, b_ctrl, b_pins, ec, ep);
         end
         ec = exp_ctrl(k_small, 8, S_HT, 4, S_VT);
         ep = exp_pins(k_small, S_PIPE, 8, 2, 2, S_HT, 4, 1, 1, S_VT, 1'b1, 1'b1, prev_rgb);
         checks++;
         if ({s_ctrl, s_pins} !== {ec, ep}) begin
            errors++;
            $display("FAIL after_reset_small k=%0d got %h %h want %h %h", k_small, s_ctrl, s_pins, ec, ep);
         end
      end
   endtask

   task automatic test_pixel_20_8();
      int target, budget;
      logic [11:0] want;
      target = 8 * B_HT + 20 + B_PIPE + 1;
      budget = 0;
      while (k_big != target && budget < 20000) begin
         @(negedge vgaclk);
         budget++;
      end
`ifdef VGA_TEST_PATTERN_EN
      want = 12'h251;
`else
      want = prev_rgb;
`endif
      checks++;
      if (k_big != target || {b_red_out, b_green_out, b_blue_out} !== want) begin
         errors++;
         $display("FAIL pixel_20_8 k=%0d got %h want %h", k_big,
                  {b_red_out, b_green_out, b_blue_out}, want);
      end
   endtask

   initial begin
      test_reset();
      test_default_lines();
      test_default_hsync();
      test_small_geometry();
      test_reset_mid_frame();
      test_pixel_20_8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a latency-matched pixel pipeline. It generates the pixel coordinates and the display-enable request. A downstream pixel source (framebuffer, character generator) returns colour a fixed number of cycles later. The block delays sync and blanking to match that latency and drives the registered `hsync`, `vsync` and 4-bit-per-channel colour pins at top level.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, hsync pulse width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vsync pulse width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`
- `CNT_W`, 11, width of `hcount`/`vcount`; must hold H_TOTAL-1 and V_TOTAL-1
- `COLOR_W`, 4, bits per colour channel
- `PIPE`, 2, pixel-source latency in cycles from `hcount`/`vcount`/`de_req` to `*_in` valid; range 0..7

Ports:
- `vgaclk`  in  1  pixel clock
- `sys_rst`  in  1  asynchronous, active-high reset
- `hcount`  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- `vcount`  out  CNT_W  current line, 0..V_TOTAL-1
- `de_req`  out  1  high when `hcount < H_ACTIVE` and `vcount < V_ACTIVE`
- `frame_start`  out  1  one-cycle pulse when hcount=0 and vcount=0
- `line_start`  out  1  one-cycle pulse when hcount=0
- `red_in`, `green_in`, `blue_in`  in  COLOR_W each  colour for the request issued PIPE cycles earlier
- `hsync`, `vsync`  out  1  registered sync outputs
- `red_out`, `green_out`, `blue_out`  out  COLOR_W each  registered colour; zero while blanked

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- `hcount` increments every cycle and wraps from H_TOTAL-1 to 0.
- `vcount` increments on that wrap and wraps from V_TOTAL-1 to 0 on the same cycle that `hcount` wraps.
- Raw hsync is asserted for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Raw vsync is asserted for whole lines with `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). It changes only at `hcount`=0.
- `de_req`, raw hsync and raw vsync pass through a PIPE-stage shift register. A final output register then applies the polarity parameters.
- The output register loads `*_out` = `*_in` when the delayed de is 1, else 0.
- Reset, asynchronous, applies to every flop:
  - `hcount`=0, `vcount`=0.
  - All delay-line stages hold de=0 and sync deasserted.
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL.
  - Colour outputs=0; `frame_start`=`line_start`=0.
- First cycle after `sys_rst` falls: `hcount`=0, `vcount`=0, `de_req`=1, `frame_start`=1.
- Reset asserted mid-frame forces all outputs to their reset values immediately. No partial line is emitted after release.
- The delay line contains no combinational path from `*_in` to any output.

## Timing
- `hcount`, `vcount`, `de_req`, `frame_start` and `line_start` are registered and mutually aligned.
- Total latency from request to pins is PIPE+1 cycles: the request issued at cycle t (`hcount`=x) produces the colour on `*_out` at t+PIPE+1.
- `hsync` and `vsync` carry the same PIPE+1 delay, so pixel/sync alignment on the pins is independent of PIPE.
- With PIPE=0, `*_in` is sampled in the same cycle as the request and the outputs appear one cycle later.
- Default hsync pulse on the pins: low for 128 cycles, starting 840+PIPE+1 cycles after the line start.
- Default vsync pulse on the pins: 4 lines long, starting at line 601.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - An internal pattern replaces `*_in`, using `vcount[5:2]`, `hcount[5:2]` and `hcount[7:4]` for red/green/blue. Each value is truncated or zero-extended to COLOR_W.
  - The pattern is taken from the counters delayed by PIPE stages.
  - The `*_in` ports stay on the interface and are ignored.
- `VGA_TEST_PATTERN_EN` not defined: colour comes from `*_in` only, and no pattern logic is present.

## Test plan
- Reset release at defaults → `frame_start`=1 on the first cycle. `line_start` pulses every 1056 cycles and `frame_start` every 663168 cycles.
- Hold `*_in`=4'hA with PIPE=2 → `*_out`=A on the pins for exactly 800 cycles per line across lines 0..599. Outputs are 0 for lines 600..627 and for hcount 800..1055 (pin-relative).
- Defaults, active-low sync → `hsync` low for 128 cycles per line, beginning at request hcount 840 + 3 cycles. `vsync` low during lines 601..604 only.
- Set HSYNC_POL=1, VSYNC_POL=1, small geometry (H 8/2/2/2, V 4/1/1/1) → hsync high 2 cycles per 14-cycle line; vsync high for 1 line of 7; counters wrap at 13 and 6.
- Assert `sys_rst` at hcount=500, vcount=300 for 3 cycles → all outputs take reset values the same cycle. After release, counting restarts at 0/0 and the first colour appears PIPE+1 cycles later.
- Define `VGA_TEST_PATTERN_EN` and drive `*_in` with random values → at pixel (x=20, y=8) the outputs are red=2, green=5, blue=1.
